// File: rtl/ir_prefetch.sv
// Instruction register fed by a small prefetch FIFO.
// Assembles one-word or two-word (opcode + immediate) instructions for the controller.
module ir_prefetch #(
  parameter  int IW    = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] opcode,
  output logic [IW-1:0] immediate,
  output logic          has_imm,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  // state    | meaning
  // S_EMPTY  | no instruction held, waiting for an opcode word
  // S_HALF   | opcode held, waiting for its immediate word
  // S_FULL   | complete instruction presented on out_valid
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [IW-1:0] head;
  logic          has_words;
  logic          push, pop, load_op, load_imm;

  assign head      = mem[rd_ptr];
  assign has_words = (count != '0);
  // RST gating keeps in_ready low for the whole time reset is held
  assign in_ready  = RST && (count < LW'(DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = (state == S_FULL);
  assign level     = count;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_op   = 1'b0;
    load_imm  = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (has_words) begin
            pop       = 1'b1;
            load_op   = 1'b1;
            state_nxt = head[IW-1] ? S_HALF : S_FULL;
          end
        end
        S_HALF: begin
          if (has_words) begin
            pop       = 1'b1;
            load_imm  = 1'b1;
            state_nxt = S_FULL;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            if (has_words) begin
              pop       = 1'b1;
              load_op   = 1'b1;
              state_nxt = head[IW-1] ? S_HALF : S_FULL;
            end else begin
              state_nxt = S_EMPTY;
            end
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only words below count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      opcode    <= '0;
      immediate <= '0;
      has_imm   <= 1'b0;
    end else if (flush) begin
      opcode    <= '0;
      immediate <= '0;
      has_imm   <= 1'b0;
    end else if (load_op) begin
      opcode    <= head;
      immediate <= '0;
      has_imm   <= 1'b0;
    end else if (load_imm) begin
      immediate <= head;
      has_imm   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_prefetch.sv
// Scoreboard bench for ir_prefetch: directed scenarios plus a randomized stream
// checked against instruction records built before serialization into words.
module tb_ir_prefetch;
  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] opcode;
  logic [IW-1:0] immediate;
  logic          has_imm;
  logic [LW-1:0] level;

  ir_prefetch #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .immediate(immediate), .has_imm(has_imm), .level(level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [2*IW:0] exp_q[$];
  logic [2*IW:0] mon_e;
  logic [IW-1:0] wq[$];
  logic          drv_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*IW:0] ins(input logic [IW-1:0] op, input logic [IW-1:0] imm,
                                        input logic h);
    return {h, imm, op};
  endfunction

  // Monitor: every consumed instruction must be the next expected one.
  always @(negedge clk) begin
    if (RST && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue: got op=0x%0h imm=0x%0h has_imm=%0b expected no instruction at %0t",
                 opcode, immediate, has_imm, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue", 32'({has_imm, immediate, opcode}), 32'(mon_e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] w);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word 0x%0h got no in_ready, required accept within 200 cycles", w);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d instructions still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    // reset held from time 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    #2 RST = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    step();

    // reset mid-assembly
    in_valid = 1'b1;
    in_data  = 8'h81;
    step();
    in_data = 8'h40;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("half_opcode", 32'(opcode), 32'h81);
    chk("half_out_valid", 32'(out_valid), 32'd0);
    chk("half_level", 32'(level), 32'd1);
    #1 RST = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_opcode", 32'(opcode), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
    step();

    // single-word stream, back to back
    out_ready = 1'b1;
    exp_q.push_back(ins(8'h11, 8'h00, 1'b0));
    exp_q.push_back(ins(8'h22, 8'h00, 1'b0));
    exp_q.push_back(ins(8'h33, 8'h00, 1'b0));
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_data = 8'h22;
    @(negedge clk);
    chk("sw_latency_out_valid", 32'(out_valid), 32'd0);
    step();
    in_data = 8'h33;
    @(negedge clk);
    chk("sw_out_valid", 32'(out_valid), 32'd1);
    chk("sw_op0", 32'(opcode), 32'h11);
    chk("sw_imm0", 32'(immediate), 32'd0);
    chk("sw_has_imm0", 32'(has_imm), 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sw_op1", 32'(opcode), 32'h22);
    chk("sw_valid1", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    chk("sw_op2", 32'(opcode), 32'h33);
    chk("sw_has_imm2", 32'(has_imm), 32'd0);
    step();
    out_ready = 1'b0;
    drain("single");

    // two-word instruction held under stall
    exp_q.push_back(ins(8'h85, 8'h9A, 1'b1));
    send(8'h85);
    send(8'h9A);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("tw_out_valid", 32'(out_valid), 32'd1);
      chk("tw_opcode", 32'(opcode), 32'h85);
      chk("tw_immediate", 32'(immediate), 32'h9A);
      chk("tw_has_imm", 32'(has_imm), 32'd1);
      chk("tw_level", 32'(level), 32'd0);
      step();
    end
    drain("twoword");

    // full FIFO
    for (int i = 1; i <= 6; i++) exp_q.push_back(ins(IW'(i), 8'h00, 1'b0));
    send(8'h01);
    step();
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h05);
    in_valid = 1'b1;
    in_data  = 8'h06;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_level", 32'(level), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_opcode", 32'(opcode), 32'h01);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_refill_level", 32'(level), 32'd4);
    chk("full_next_opcode", 32'(opcode), 32'h02);
    step();
    drain("full");

    // flush with level 3 and IR full
    exp_q.push_back(ins(8'h21, 8'h00, 1'b0));
    send(8'h21);
    step();
    send(8'h22);
    send(8'h23);
    send(8'h24);
    @(negedge clk);
    chk("preflush_level", 32'(level), 32'd3);
    chk("preflush_out_valid", 32'(out_valid), 32'd1);
    step();
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h25;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_opcode", 32'(opcode), 32'd0);
      step();
    end
    exp_q.push_back(ins(8'h30, 8'h00, 1'b0));
    send(8'h30);
    drain("postflush");

    // randomized mixed stream, enough words to wrap the pointers many times
    for (int i = 0; i < 3 * DEPTH + 1 + 24; i++) begin
      logic [IW-1:0] op, imm;
      logic          ext;
      ext = 1'($urandom_range(0, 1));
      op  = IW'($urandom);
      op[IW-1] = ext;
      imm = ext ? IW'($urandom) : '0;
      exp_q.push_back(ins(op, imm, ext));
      wq.push_back(op);
      if (ext) wq.push_back(imm);
    end
    drv_done = 1'b0;
    fork
      begin
        for (int k = 0; k < wq.size(); k++) begin
          repeat ($urandom_range(0, 2)) step();
          send(wq[k]);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
